control_sequencer: RTL and testbench
====================================

# control_sequencer

Hardwired control unit for the datapath: a Moore state machine that issues per-phase control strobes (T0–T7) for instruction fetch and execute. Generalises the fixed single-instruction LD sequence into a multi-instruction sequencer that decodes the IR opcode and stretches memory phases with a `mem_ready` handshake. It sits beside `DataPath`, drives its control inputs and reads back the IR.

## Interface
- `OPCODE_W`, 5: opcode field width, taken from `ir[31:32-OPCODE_W]`.
- `ALU_OP_W`, 5: width of `alu_op`, which drives DataPath `opcode`.
- `WAIT_MAX`, 15: memory-wait watchdog limit in cycles; active only with `CTRL_TIMEOUT_EN`.

Ports:
- `clock` in 1: sole clock, rising edge.
- `clear` in 1: synchronous, active-high reset.
- `run` in 1: permits starting a new fetch from IDLE or after an instruction completes.
- `ir` in 32: IR contents from DataPath.
- `mem_ready` in 1: memory has completed the current Read/Write.
- Strobes out, 1 bit each: `PCout`, `PCin`, `IncPC`, `MARin`, `MDRin`, `MDRout`, `IRin`, `Yin`, `ZLowIn`, `Zlowout`, `Read`, `Write`, `Gra`, `Grb`, `Grc`, `Rin`, `Rout`, `BAout`, `Cout`.
- `alu_op` out `ALU_OP_W`: ALU operation code.
- `state` out 4: current state code, for debug.
- `done` out 1: high during the final step of each instruction.
- `halted` out 1: high in HALT.
- `error` out 1: high in ERROR.

## Operation
- States: IDLE=0000, T0=0111 … T7=1110 (consecutive codes), HALT=0001, ERROR=0010.
- All outputs are decoded from `state` plus the latched opcode (Moore outputs). Any strobe not listed for a state is 0. `alu_op` is 0 except in T4.
- IDLE → T0 when `run`=1; otherwise IDLE holds.
- Fetch, common to all instructions:
  - T0: PCout, MARin, IncPC, ZLowIn.
  - T1: Zlowout, PCin, Read, MDRin. Holds in T1 while `mem_ready`=0.
  - T2: MDRout, IRin.
- Opcode decode happens combinationally from `ir` during T3. The opcode is latched into `op_q` on the T3→T4 edge. Opcodes:
  - ld = 00000
  - ldi = 00001
  - st = 00010
  - ALU R-type = 00011–01010; `alu_op` = opcode.
  - addi = 01011
  - nop = 11010
  - halt = 11011
  - Any other opcode is illegal.
- ld:
  - T3: Grb, BAout, Yin.
  - T4: Cout, `alu_op`=00011, ZLowIn.
  - T5: Zlowout, MARin.
  - T6: Read, MDRin. Holds while `mem_ready`=0.
  - T7: MDRout, Gra, Rin, done.
- ldi: T3 and T4 as for ld; T5: Zlowout, Gra, Rin, done.
- st:
  - T3–T5 as for ld.
  - T6: Gra, Rout, MDRin, with Read=0.
  - T7: Write, done. Holds while `mem_ready`=0; `done` is asserted only on the cycle where `mem_ready`=1.
- R-type:
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, `alu_op`=`op_q`, ZLowIn.
  - T5: Zlowout, Gra, Rin, done.
- addi:
  - T3: Grb, Rout, Yin.
  - T4: Cout, `alu_op`=00011, ZLowIn.
  - T5: Zlowout, Gra, Rin, done.
- nop: T3 has no strobes and asserts done.
- halt: T3 → HALT. HALT holds until `clear`.
- Illegal opcode: T3 → ERROR. ERROR holds until `clear`.
- After a `done` step: go to T0 if `run`=1, else IDLE.
- `run` is ignored mid-instruction; dropping it never aborts an instruction.

## Timing
- Every output is 0 out of reset. `state` resets to IDLE.
- `clear` has priority over every transition, including wait states. An instruction in progress is abandoned on that edge, and no strobe is asserted in the following cycle.
- Wait states: T1, ld-T6 and st-T7 repeat the same strobes every cycle until `mem_ready`=1 is sampled, then advance on that edge. With `mem_ready` tied high, each of these steps lasts exactly one cycle.
- Instruction length with `mem_ready`=1:
  - ld and st: 8 cycles (T0–T7).
  - ldi, R-type and addi: 6 cycles.
  - nop: 4 cycles.
- Back-to-back: T0 of the next instruction directly follows the done cycle when `run`=1. There are no bubbles.

## Configuration
- `CTRL_TIMEOUT_EN` defined:
  - A 4-bit+ wait counter clears on entry to each wait state and increments each cycle that `mem_ready`=0.
  - When the counter reaches `WAIT_MAX`, the next edge goes to ERROR and `error`=1.
  - The counter resets on `clear`.
- `CTRL_TIMEOUT_EN` undefined: no counter; wait states hold indefinitely and ERROR is reachable only through an illegal opcode.

## Test plan
- ld: `mem_ready`=1, `run`=1, `ir`=0x00800000 supplied from T3. Required response:
  - States T0…T7.
  - T4: Cout=1, `alu_op`=00011.
  - T7: MDRout=Gra=Rin=done=1.
  - Next state T0.
- ld with `mem_ready` low for 3 cycles in T1 and 2 cycles in T6: T1 lasts 4 cycles and T6 lasts 3 cycles, with the same strobes on every cycle; 13 cycles total.
- R-type opcode 00100, then addi, back-to-back: T4 gives `alu_op`=00100 with Grc=Rout=1, then `alu_op`=00011 with Cout=1; each instruction completes in 6 cycles with no gap.
- Opcode 11111: T3 → ERROR with `error`=1, all strobes 0; `clear` → IDLE with `error`=0.
- halt, then `clear` pulsed during T5 of a later ld: `halted`=1 in HALT; for the ld, the cycle after the `clear` edge has `state`=IDLE and every strobe 0.
- `CTRL_TIMEOUT_EN` defined, `WAIT_MAX`=15, `mem_ready` held low in T1: ERROR is entered after 15 wait cycles. Without the macro, the sequencer is still in T1 after 100 cycles.

Source files
------------

// File: rtl/control_sequencer.sv
// control_sequencer
// ------------------------------------------------------------------------
// Hardwired Moore control unit for the DataPath. It runs the common fetch
// (T0-T2), decodes the IR opcode in T3, and then steps through the
// execute phases for ld, ldi, st, ALU R-type, addi, nop and halt. The
// memory phases (T1, ld-T6, st-T7) stretch until mem_ready is seen high.
//
// Build option:
//   CTRL_TIMEOUT_EN  - when defined, a watchdog counts cycles spent waiting
//                      on mem_ready. After WAIT_MAX such cycles in one wait
//                      state the sequencer goes to ERROR. When undefined,
//                      wait states hold indefinitely.
//
// Parameters:
//   OPCODE_W  opcode field width, taken from ir[31 -: OPCODE_W]
//   ALU_OP_W  width of alu_op (drives DataPath opcode)
//   WAIT_MAX  memory-wait watchdog limit in cycles (CTRL_TIMEOUT_EN only)
//
// Ports:
//   clock      rising-edge clock
//   clear      synchronous active-high reset, beats every transition
//   run        allows a new fetch from IDLE or after a done step
//   ir         IR contents read back from DataPath
//   mem_ready  memory finished the current Read/Write
//   PCout..Cout  one-bit DataPath control strobes
//   alu_op     ALU operation, non-zero only in T4
//   state      current state code (debug)
//   done       final step of an instruction
//   halted     in HALT
//   error      in ERROR
// ------------------------------------------------------------------------
module control_sequencer #(
    parameter int OPCODE_W = 5,
    parameter int ALU_OP_W = 5,
    parameter int WAIT_MAX = 15
) (
    input  logic                clock,
    input  logic                clear,
    input  logic                run,
    input  logic [31:0]         ir,
    input  logic                mem_ready,
    output logic                PCout,
    output logic                PCin,
    output logic                IncPC,
    output logic                MARin,
    output logic                MDRin,
    output logic                MDRout,
    output logic                IRin,
    output logic                Yin,
    output logic                ZLowIn,
    output logic                Zlowout,
    output logic                Read,
    output logic                Write,
    output logic                Gra,
    output logic                Grb,
    output logic                Grc,
    output logic                Rin,
    output logic                Rout,
    output logic                BAout,
    output logic                Cout,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [3:0]          state,
    output logic                done,
    output logic                halted,
    output logic                error
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'b0000,
        S_HALT  = 4'b0001,
        S_ERROR = 4'b0010,
        S_T0    = 4'b0111,
        S_T1    = 4'b1000,
        S_T2    = 4'b1001,
        S_T3    = 4'b1010,
        S_T4    = 4'b1011,
        S_T5    = 4'b1100,
        S_T6    = 4'b1101,
        S_T7    = 4'b1110
    } state_t;

    // Instruction class, so the state machine and strobe decode do not
    // have to repeat opcode range checks.
    typedef enum logic [2:0] {
        C_LD, C_LDI, C_ST, C_ALU, C_ADDI, C_NOP, C_HALT, C_ILL
    } iclass_t;

    localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(3);

    function automatic iclass_t classify(input logic [OPCODE_W-1:0] op);
        iclass_t c;
        if      (op == OPCODE_W'(5'b00000)) c = C_LD;
        else if (op == OPCODE_W'(5'b00001)) c = C_LDI;
        else if (op == OPCODE_W'(5'b00010)) c = C_ST;
        else if (op >= OPCODE_W'(5'b00011) && op <= OPCODE_W'(5'b01010)) c = C_ALU;
        else if (op == OPCODE_W'(5'b01011)) c = C_ADDI;
        else if (op == OPCODE_W'(5'b11010)) c = C_NOP;
        else if (op == OPCODE_W'(5'b11011)) c = C_HALT;
        else                                c = C_ILL;
        return c;
    endfunction

    state_t                state_q;
    logic [OPCODE_W-1:0]   op_q;
    logic [OPCODE_W-1:0]   ir_op;
    iclass_t               ir_cls;   // class of the live IR, used in T3
    iclass_t               q_cls;    // class of the latched opcode, T4 onwards
    state_t                after_done;

    assign ir_op      = ir[31 -: OPCODE_W];
    assign ir_cls     = classify(ir_op);
    assign q_cls      = classify(op_q);
    assign after_done = run ? S_T0 : S_IDLE;

    // Only the opcode field of the IR matters here.
    logic [31-OPCODE_W:0] unused_ir;
    assign unused_ir = ir[31-OPCODE_W:0];

`ifdef CTRL_TIMEOUT_EN
    localparam int WC_W = ($clog2(WAIT_MAX + 1) < 4) ? 4 : $clog2(WAIT_MAX + 1);
    logic [WC_W-1:0] wait_cnt;
    logic            in_wait;

    assign in_wait = (state_q == S_T1) ||
                     (state_q == S_T6 && q_cls == C_LD) ||
                     (state_q == S_T7 && q_cls == C_ST);
`else
    logic [3:0] unused_wait_max;
    assign unused_wait_max = 4'(WAIT_MAX);
`endif

    // --------------------------------------------------------------------
    // State register and sequencing
    // --------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
`ifdef CTRL_TIMEOUT_EN
            wait_cnt <= '0;
`endif
        end else begin
`ifdef CTRL_TIMEOUT_EN
            // Zero whenever not stalled, so each wait state starts fresh.
            wait_cnt <= '0;
`endif
            case (state_q)
                S_IDLE:  if (run) state_q <= S_T0;
                S_T0:    state_q <= S_T1;
                S_T1:    if (mem_ready) state_q <= S_T2;
                S_T2:    state_q <= S_T3;
                S_T3: begin
                    op_q <= ir_op;
                    case (ir_cls)
                        C_NOP:   state_q <= after_done;
                        C_HALT:  state_q <= S_HALT;
                        C_ILL:   state_q <= S_ERROR;
                        default: state_q <= S_T4;
                    endcase
                end
                S_T4:    state_q <= S_T5;
                S_T5: begin
                    if (q_cls == C_LD || q_cls == C_ST) state_q <= S_T6;
                    else                                state_q <= after_done;
                end
                // ld waits for read data here; st only stages MDR.
                S_T6:    if (q_cls == C_ST || mem_ready) state_q <= S_T7;
                // st waits for the write to land here; ld finishes at once.
                S_T7:    if (q_cls == C_LD || mem_ready) state_q <= after_done;
                S_HALT:  state_q <= S_HALT;
                S_ERROR: state_q <= S_ERROR;
                default: state_q <= S_ERROR;
            endcase
`ifdef CTRL_TIMEOUT_EN
            // Overrides the hold above once the stall has lasted WAIT_MAX cycles.
            if (in_wait && !mem_ready) begin
                if (wait_cnt >= WC_W'(WAIT_MAX - 1)) state_q  <= S_ERROR;
                else                                 wait_cnt <= wait_cnt + 1'b1;
            end
`endif
        end
    end

    // --------------------------------------------------------------------
    // Strobe decode. Decoded from the state register (plus the opcode) so
    // T3 can react to the IR loaded at the end of T2, and st-T7 can
    // qualify done with mem_ready.
    // --------------------------------------------------------------------
    always_comb begin
        PCout   = 1'b0;  PCin    = 1'b0;  IncPC  = 1'b0;  MARin  = 1'b0;
        MDRin   = 1'b0;  MDRout  = 1'b0;  IRin   = 1'b0;  Yin    = 1'b0;
        ZLowIn  = 1'b0;  Zlowout = 1'b0;  Read   = 1'b0;  Write  = 1'b0;
        Gra     = 1'b0;  Grb     = 1'b0;  Grc    = 1'b0;  Rin    = 1'b0;
        Rout    = 1'b0;  BAout   = 1'b0;  Cout   = 1'b0;
        alu_op  = '0;
        done    = 1'b0;
        case (state_q)
            S_T0: begin
                PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; ZLowIn = 1'b1;
            end
            S_T1: begin
                Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
            end
            S_T2: begin
                MDRout = 1'b1; IRin = 1'b1;
            end
            S_T3: begin
                case (ir_cls)
                    C_LD, C_LDI, C_ST: begin
                        Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
                    end
                    C_ALU, C_ADDI: begin
                        Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                    end
                    C_NOP:   done = 1'b1;
                    default: ;
                endcase
            end
            S_T4: begin
                ZLowIn = 1'b1;
                if (q_cls == C_ALU) begin
                    Grc    = 1'b1;
                    Rout   = 1'b1;
                    alu_op = ALU_OP_W'(op_q);
                end else begin
                    // Address/immediate add: base or Rb plus the C field.
                    Cout   = 1'b1;
                    alu_op = ALU_ADD;
                end
            end
            S_T5: begin
                Zlowout = 1'b1;
                if (q_cls == C_LD || q_cls == C_ST) begin
                    MARin = 1'b1;
                end else begin
                    Gra = 1'b1; Rin = 1'b1; done = 1'b1;
                end
            end
            S_T6: begin
                MDRin = 1'b1;
                if (q_cls == C_ST) begin
                    Gra = 1'b1; Rout = 1'b1;
                end else begin
                    Read = 1'b1;
                end
            end
            S_T7: begin
                if (q_cls == C_ST) begin
                    Write = 1'b1;
                    done  = mem_ready;
                end else begin
                    MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; done = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign state  = state_q;
    assign halted = (state_q == S_HALT);
    assign error  = (state_q == S_ERROR);

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

    localparam logic [3:0] S_IDLE = 4'b0000, S_HALT = 4'b0001, S_ERR = 4'b0010;
    localparam logic [3:0] S_T0 = 4'd7,  S_T1 = 4'd8,  S_T2 = 4'd9,  S_T3 = 4'd10;
    localparam logic [3:0] S_T4 = 4'd11, S_T5 = 4'd12, S_T6 = 4'd13, S_T7 = 4'd14;

    // Strobe bit positions in the packed observation, PCout first.
    localparam logic [18:0] PCOUT = 19'd1 << 18, PCIN = 19'd1 << 17, INCPC = 19'd1 << 16;
    localparam logic [18:0] MARIN = 19'd1 << 15, MDRIN = 19'd1 << 14, MDROUT = 19'd1 << 13;
    localparam logic [18:0] IRIN = 19'd1 << 12, YIN = 19'd1 << 11, ZLOWIN = 19'd1 << 10;
    localparam logic [18:0] ZLOWOUT = 19'd1 << 9, READ = 19'd1 << 8, WRITE = 19'd1 << 7;
    localparam logic [18:0] GRA = 19'd1 << 6, GRB = 19'd1 << 5, GRC = 19'd1 << 4;
    localparam logic [18:0] RIN = 19'd1 << 3, ROUT = 19'd1 << 2, BAOUT = 19'd1 << 1;
    localparam logic [18:0] COUT = 19'd1;
    localparam logic [18:0] NONE = 19'd0;

    localparam logic [31:0] IR_LD   = 32'h0080_0000;
    localparam logic [31:0] IR_LDI  = 32'h0800_0000;
    localparam logic [31:0] IR_ST   = 32'h1000_0000;
    localparam logic [31:0] IR_R4   = 32'h2000_0000;  // opcode 00100
    localparam logic [31:0] IR_ADDI = 32'h5800_0000;  // opcode 01011
    localparam logic [31:0] IR_NOP  = 32'hD000_0000;  // opcode 11010
    localparam logic [31:0] IR_HALT = 32'hD800_0000;  // opcode 11011
    localparam logic [31:0] IR_ILL  = 32'hF800_0000;  // opcode 11111

    logic        clock = 1'b0;
    logic        clear, run, mem_ready;
    logic [31:0] ir;
    logic PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, ZLowIn, Zlowout;
    logic Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, Cout;
    logic [4:0]  alu_op;
    logic [3:0]  state;
    logic        done, halted, error;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    control_sequencer dut (
        .clock(clock), .clear(clear), .run(run), .ir(ir), .mem_ready(mem_ready),
        .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
        .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .ZLowIn(ZLowIn), .Zlowout(Zlowout),
        .Read(Read), .Write(Write), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin),
        .Rout(Rout), .BAout(BAout), .Cout(Cout), .alu_op(alu_op), .state(state),
        .done(done), .halted(halted), .error(error)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] est, input logic [18:0] estb,
                       input logic [4:0] ealu, input logic edn, input logic ehl,
                       input logic eer);
        logic [30:0] obs, exp;
        #1;
        obs = {state, PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, ZLowIn,
               Zlowout, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, Cout,
               alu_op, done, halted, error};
        exp = {est, estb, ealu, edn, ehl, eer};
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    // Common fetch with mem_ready high: T0, T1, T2 one cycle each.
    task automatic fetch(input string tag);
        step(); chk({tag, "_t0"}, S_T0, PCOUT | MARIN | INCPC | ZLOWIN, 5'd0, 0, 0, 0);
        step(); chk({tag, "_t1"}, S_T1, ZLOWOUT | PCIN | READ | MDRIN, 5'd0, 0, 0, 0);
        step(); chk({tag, "_t2"}, S_T2, MDROUT | IRIN, 5'd0, 0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        clear = 1'b1; run = 1'b0; mem_ready = 1'b1; ir = 32'h0;
        step(); step();
        chk("reset", S_IDLE, NONE, 5'd0, 0, 0, 0);
        clear = 1'b0; run = 1'b1;

        // ld, no wait
        fetch("ld");
        step(); ir = IR_LD; chk("ld_t3", S_T3, GRB | BAOUT | YIN, 5'd0, 0, 0, 0);
        step(); chk("ld_t4", S_T4, COUT | ZLOWIN, 5'b00011, 0, 0, 0);
        step(); chk("ld_t5", S_T5, ZLOWOUT | MARIN, 5'd0, 0, 0, 0);
        step(); chk("ld_t6", S_T6, READ | MDRIN, 5'd0, 0, 0, 0);
        step(); chk("ld_t7", S_T7, MDROUT | GRA | RIN, 5'd0, 1, 0, 0);

        // ld with 3 wait cycles in T1 and 2 in T6: 13 cycles total
        step(); chk("ldw_t0", S_T0, PCOUT | MARIN | INCPC | ZLOWIN, 5'd0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(); mem_ready = (i == 3);
            chk("ldw_t1", S_T1, ZLOWOUT | PCIN | READ | MDRIN, 5'd0, 0, 0, 0);
        end
        step(); chk("ldw_t2", S_T2, MDROUT | IRIN, 5'd0, 0, 0, 0);
        step(); ir = IR_LD; chk("ldw_t3", S_T3, GRB | BAOUT | YIN, 5'd0, 0, 0, 0);
        step(); chk("ldw_t4", S_T4, COUT | ZLOWIN, 5'b00011, 0, 0, 0);
        step(); chk("ldw_t5", S_T5, ZLOWOUT | MARIN, 5'd0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(); mem_ready = (i == 2);
            chk("ldw_t6", S_T6, READ | MDRIN, 5'd0, 0, 0, 0);
        end
        step(); chk("ldw_t7", S_T7, MDROUT | GRA | RIN, 5'd0, 1, 0, 0);

        // R-type 00100 then addi, back to back
        fetch("rt");
        step(); ir = IR_R4; chk("rt_t3", S_T3, GRB | ROUT | YIN, 5'd0, 0, 0, 0);
        step(); chk("rt_t4", S_T4, GRC | ROUT | ZLOWIN, 5'b00100, 0, 0, 0);
        step(); chk("rt_t5", S_T5, ZLOWOUT | GRA | RIN, 5'd0, 1, 0, 0);
        fetch("addi");
        step(); ir = IR_ADDI; chk("addi_t3", S_T3, GRB | ROUT | YIN, 5'd0, 0, 0, 0);
        step(); chk("addi_t4", S_T4, COUT | ZLOWIN, 5'b00011, 0, 0, 0);
        step(); chk("addi_t5", S_T5, ZLOWOUT | GRA | RIN, 5'd0, 1, 0, 0);

        // st: T6 does not wait; T7 holds until mem_ready, done only then
        fetch("st");
        step(); ir = IR_ST; chk("st_t3", S_T3, GRB | BAOUT | YIN, 5'd0, 0, 0, 0);
        step(); chk("st_t4", S_T4, COUT | ZLOWIN, 5'b00011, 0, 0, 0);
        step(); chk("st_t5", S_T5, ZLOWOUT | MARIN, 5'd0, 0, 0, 0);
        step(); mem_ready = 1'b0; chk("st_t6", S_T6, GRA | ROUT | MDRIN, 5'd0, 0, 0, 0);
        step(); chk("st_t7_wait", S_T7, WRITE, 5'd0, 0, 0, 0);
        step(); mem_ready = 1'b1; chk("st_t7_done", S_T7, WRITE, 5'd0, 1, 0, 0);

        // ldi with run dropped mid-instruction: completes, then IDLE
        fetch("ldi");
        step(); ir = IR_LDI; chk("ldi_t3", S_T3, GRB | BAOUT | YIN, 5'd0, 0, 0, 0);
        step(); run = 1'b0; chk("ldi_t4", S_T4, COUT | ZLOWIN, 5'b00011, 0, 0, 0);
        step(); chk("ldi_t5", S_T5, ZLOWOUT | GRA | RIN, 5'd0, 1, 0, 0);
        step(); chk("idle_a", S_IDLE, NONE, 5'd0, 0, 0, 0);
        step(); chk("idle_b", S_IDLE, NONE, 5'd0, 0, 0, 0);
        run = 1'b1;

        // nop: 4 cycles, done in T3
        fetch("nop");
        step(); ir = IR_NOP; chk("nop_t3", S_T3, NONE, 5'd0, 1, 0, 0);

        // halt, held until clear
        fetch("halt");
        step(); ir = IR_HALT; chk("halt_t3", S_T3, NONE, 5'd0, 0, 0, 0);
        step(); chk("halt_a", S_HALT, NONE, 5'd0, 0, 1, 0);
        step(); clear = 1'b1; chk("halt_b", S_HALT, NONE, 5'd0, 0, 1, 0);
        step(); clear = 1'b0; chk("halt_clr", S_IDLE, NONE, 5'd0, 0, 0, 0);

        // clear during T5 of ld abandons it
        fetch("ldc");
        step(); ir = IR_LD; chk("ldc_t3", S_T3, GRB | BAOUT | YIN, 5'd0, 0, 0, 0);
        step(); chk("ldc_t4", S_T4, COUT | ZLOWIN, 5'b00011, 0, 0, 0);
        step(); chk("ldc_t5", S_T5, ZLOWOUT | MARIN, 5'd0, 0, 0, 0);
        clear = 1'b1;
        step(); clear = 1'b0; chk("ldc_clr", S_IDLE, NONE, 5'd0, 0, 0, 0);

        // illegal opcode 11111
        fetch("ill");
        step(); ir = IR_ILL; chk("ill_t3", S_T3, NONE, 5'd0, 0, 0, 0);
        step(); chk("ill_err_a", S_ERR, NONE, 5'd0, 0, 0, 1);
        step(); clear = 1'b1; chk("ill_err_b", S_ERR, NONE, 5'd0, 0, 0, 1);
        step(); clear = 1'b0; chk("ill_clr", S_IDLE, NONE, 5'd0, 0, 0, 0);

        // memory never answers in T1
        step(); chk("to_t0", S_T0, PCOUT | MARIN | INCPC | ZLOWIN, 5'd0, 0, 0, 0);
        mem_ready = 1'b0;
`ifdef CTRL_TIMEOUT_EN
        for (int i = 0; i < 15; i++) begin
            step(); chk("to_t1", S_T1, ZLOWOUT | PCIN | READ | MDRIN, 5'd0, 0, 0, 0);
        end
        step(); chk("to_err", S_ERR, NONE, 5'd0, 0, 0, 1);
`else
        for (int i = 0; i < 100; i++) begin
            step();
            if (i == 0 || i == 99)
                chk("to_hold", S_T1, ZLOWOUT | PCIN | READ | MDRIN, 5'd0, 0, 0, 0);
        end
`endif
        clear = 1'b1;
        step(); clear = 1'b0; chk("final_clr", S_IDLE, NONE, 5'd0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
